// File: rtl/reg_files_pkg.sv
// Shared constants for the register file and the ID stage: default widths,
// the zero-register address and the rs/rt field positions in the packed read-address bus.
package reg_files_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int RS_HI = 9;
    localparam int RS_LO = 5;
    localparam int RT_HI = 4;
    localparam int RT_LO = 0;

endpackage

// File: rtl/reg_files_if.sv
// ID/WB-side connection to the register file: packed read addresses,
// write-back destination and data, and the two read results.
interface reg_files_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic [2*ADDR_W-1:0] rs_rt;
    logic [ADDR_W-1:0]   rwd;
    logic [DATA_W-1:0]   wb_data;
    logic [DATA_W-1:0]   val_rs;
    logic [DATA_W-1:0]   val_rt;

    modport master (
        output rs_rt,
        output rwd,
        output wb_data,
        input  val_rs,
        input  val_rt
    );

    modport slave (
        input  rs_rt,
        input  rwd,
        input  wb_data,
        output val_rs,
        output val_rt
    );

endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: zero register, then same-cycle write-back bypass,
// then the stored value.
module reg_read_port
    import reg_files_pkg::*;
#(
    parameter int DATA_W = reg_files_pkg::DATA_W,
    parameter int ADDR_W = reg_files_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0]                     addr_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]      regs_i,
    input  logic [ADDR_W-1:0]                     rwd_i,
    input  logic [DATA_W-1:0]                     wb_data_i,
    input  logic                                  bypass_en_i,
    output logic [DATA_W-1:0]                     data_o
);

    // NOTE: assigning a default first on every path keeps this block free of inferred latches.
    always_comb begin
        data_o = regs_i[addr_i];
        if (addr_i == REG_ZERO) begin
            data_o = '0;
        end else if (bypass_en_i && (addr_i == rwd_i)) begin
            // addr_i is non-zero here, so a match also implies rwd_i is a real write
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/reg_files.sv
// 32 x 32-bit pipeline register file: two combinational read ports with
// write-through bypass, one synchronous write port where destination 0 means no write.
module reg_files
    import reg_files_pkg::*;
#(
    parameter int DATA_W = reg_files_pkg::DATA_W,
    parameter int ADDR_W = reg_files_pkg::ADDR_W
) (
    input  logic       CLK,
    input  logic       RST,
    reg_files_if.slave bus
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic [ADDR_W-1:0]               rs_addr;
    logic [ADDR_W-1:0]               rt_addr;
    logic                            bypass_en;

    assign rs_addr   = bus.rs_rt[RS_HI:RS_LO];
    assign rt_addr   = bus.rs_rt[RT_HI:RT_LO];
    // While reset is held the array is about to be cleared, so reads must not see wb_data
    assign bypass_en = ~RST;

    always_comb begin
        regs_d = regs_q;
        if (bus.rwd != REG_ZERO) begin
            regs_d[bus.rwd] = bus.wb_data;
        end
    end

    // NOTE: the whole array is reset here because reads of any register must be 0 after reset;
    // state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .addr_i      (rs_addr),
        .regs_i      (regs_q),
        .rwd_i       (bus.rwd),
        .wb_data_i   (bus.wb_data),
        .bypass_en_i (bypass_en),
        .data_o      (bus.val_rs)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .addr_i      (rt_addr),
        .regs_i      (regs_q),
        .rwd_i       (bus.rwd),
        .wb_data_i   (bus.wb_data),
        .bypass_en_i (bypass_en),
        .data_o      (bus.val_rt)
    );

endmodule

// File: tb/tb_reg_files.sv
// Self-checking bench for reg_files: directed vector table, full-array reset sweep,
// and randomized traffic against an array-based reference model.
module tb_reg_files;

    logic CLK;
    logic RST;

    reg_files_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

    reg_files dut (
        .CLK (CLK),
        .RST (RST),
        .bus (rf_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rwd;
        logic [31:0] wb;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rwd, input logic [31:0] wb);
        RST           = rst;
        rf_if.rs_rt   = {rs, rt};
        rf_if.rwd     = rwd;
        rf_if.wb_data = wb;
        #1;
    endtask

    // Reference: reset clears everything, otherwise a non-zero destination takes wb_data
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (rf_if.rwd != 5'd0) begin
            model[rf_if.rwd] = rf_if.wb_data;
        end
        @(negedge CLK);
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!RST && a == rf_if.rwd) return rf_if.wb_data;
        return model[a];
    endfunction

    initial begin
        //          name           rst rs     rt     rwd    wb             exp_rs         exp_rt
        vecs[0]  = '{"wr_r5_byp",   0, 5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{"rd_r5",       0, 5'd5,  5'd5,  5'd0,  32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{"rd_r0",       0, 5'd0,  5'd0,  5'd0,  32'h12345678, 32'h0,        32'h0};
        vecs[3]  = '{"wr_r7_init",  0, 5'd0,  5'd7,  5'd7,  32'h00000001, 32'h0,        32'h00000001};
        vecs[4]  = '{"byp_r7",      0, 5'd7,  5'd3,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
        vecs[5]  = '{"wr_r1",       0, 5'd7,  5'd1,  5'd1,  32'h11111111, 32'hA5A5A5A5, 32'h11111111};
        vecs[6]  = '{"wr_r31",      0, 5'd31, 5'd5,  5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[7]  = '{"rd_31_1",     0, 5'd31, 5'd1,  5'd0,  32'h0,        32'hFFFFFFFF, 32'h11111111};
        vecs[8]  = '{"wr_r4",       0, 5'd4,  5'd1,  5'd4,  32'h00000044, 32'h00000044, 32'h11111111};
        vecs[9]  = '{"rst_no_byp",  1, 5'd4,  5'd4,  5'd4,  32'h00000099, 32'h00000044, 32'h00000044};
        vecs[10] = '{"post_rst",    0, 5'd4,  5'd31, 5'd0,  32'h00000099, 32'h0,        32'h0};
        vecs[11] = '{"post_rst2",   0, 5'd7,  5'd1,  5'd0,  32'h0,        32'h0,        32'h0};

        for (int i = 0; i < 32; i++) model[i] = '0;
        drive(1'b1, 5'd0, 5'd0, 5'd4, 32'h99);
        @(negedge CLK);
        tick();

        // Directed vectors: combinational reads checked before the edge, then clocked
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].rst, vecs[v].rs, vecs[v].rt, vecs[v].rwd, vecs[v].wb);
            check({vecs[v].name, ".rs"}, rf_if.val_rs, vecs[v].exp_rs);
            check({vecs[v].name, ".rt"}, rf_if.val_rt, vecs[v].exp_rt);
            tick();
        end

        // Fill a few registers, reset with a pending write, then sweep every address
        for (int i = 1; i < 32; i += 3) begin
            drive(1'b0, 5'd0, 5'd0, 5'(i), 32'hC0DE_0000 | 32'(i));
            tick();
        end
        drive(1'b1, 5'd9, 5'd9, 5'd9, 32'hBADC0FFE);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'hFFFF_FFFF);
            check("sweep.rs", rf_if.val_rs, 32'h0);
            check("sweep.rt", rf_if.val_rt, 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic [4:0]  a_rs, a_rt, a_wd;
            logic [31:0] d;
            r    = ($urandom_range(0, 39) == 0);
            a_rs = 5'($urandom_range(0, 31));
            a_rt = ($urandom_range(0, 3) == 0) ? a_rs : 5'($urandom_range(0, 31));
            a_wd = ($urandom_range(0, 3) == 0) ? a_rs : 5'($urandom_range(0, 31));
            d    = $urandom;
            drive(r, a_rs, a_rt, a_wd, d);
            check("rand.rs", rf_if.val_rs, ref_read(a_rs));
            check("rand.rt", rf_if.val_rt, ref_read(a_rt));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_files.md
Name: reg_files

Overview:
- 32-entry x 32-bit general-purpose register file for the 5-stage pipeline.
- Two combinational read ports serve the ID stage: rs and rt addresses are packed into one bus.
- One synchronous write port is driven by the WB stage.
- R0 is hardwired to zero; write address 0 doubles as "no write" (stalls, stores, branches, jumps).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- rs_rt  input  2*ADDR_W (10)  packed read addresses: [9:5] = rs, [4:0] = rt.
- rwd  input  ADDR_W (5)  write-back destination register; 0 = no write.
- val_rs  output  DATA_W (32)  read data for rs.
- val_rt  output  DATA_W (32)  read data for rt.
- wb_data  input  DATA_W (32)  write-back data.

Behaviour:
- Storage: regs[0..31], each DATA_W bits.
- Reset:
  - On posedge CLK with RST=1, all 32 registers become 0.
  - Any write presented in that cycle is discarded.
  - After reset, val_rs and val_rt both read 0 for every address.
- Write:
  - On posedge CLK with RST=0 and rwd != 0, regs[rwd] <= wb_data.
  - rwd == 0 performs no write; regs[0] stays 0 permanently.
  - There is no separate write enable.
- Read:
  - Purely combinational, zero latency.
  - val_rs = value(rs_rt[9:5]); val_rt = value(rs_rt[4:0]).
- Read value rules, in priority order:
  - Address 0 -> 32'h0.
  - Else if RST=0 and address == rwd (rwd != 0) -> wb_data. This is the write-through bypass, so an instruction in ID sees a same-cycle WB result; the pipeline's own forwarding only covers distances 1 and 2.
  - Else -> regs[address].
- Both ports may address the same register; each port resolves independently with identical results.
- Simultaneous write and read of the same register: the read returns wb_data in that cycle, and the array holds wb_data after the edge.
- Reset asserted mid-operation: the next edge clears everything. The bypass is suppressed while RST=1, so reads show the array contents only.
- Arithmetic: none; no sign handling; data is passed through unchanged.
- No X on outputs after the first reset. Until then, outputs are undefined apart from address 0.

Decomposition:
- Shared package holds DATA_W/ADDR_W defaults, REG_ZERO = 5'd0, and the rs_rt field slice positions (RS_HI=9, RS_LO=5, RT_HI=4, RT_LO=0). The ID stage uses these too.
- Optional sub-module reg_read_port: one address in, bypass mux, one data out. Instantiate it twice.
- The storage array and write logic stay in reg_files.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read 0.
- RST=0, rwd=5, wb_data=32'hDEADBEEF, one edge; then rwd=0, rs_rt={5'd5,5'd5} -> val_rs = val_rt = 32'hDEADBEEF.
- rwd=0, wb_data=32'h12345678, one edge; then rs_rt={5'd0,5'd0} -> both 0. Repeat with rwd=0 targeting the zero register: no register changes.
- Bypass: regs[7]=32'h1 already held; present rwd=7, wb_data=32'hA5A5A5A5, rs_rt={5'd7,5'd3} before the edge -> val_rs=32'hA5A5A5A5 combinationally, val_rt=regs[3]. After the edge, regs[7]=32'hA5A5A5A5.
- Distinct ports: write r1=32'h11111111 and r31=32'hFFFFFFFF; then rs_rt={5'd31,5'd1} -> val_rs=32'hFFFFFFFF, val_rt=32'h11111111.
- Reset mid-run: registers loaded, assert RST with rwd=4, wb_data=32'h99 -> no bypass during reset. After the edge, reading r4 gives 0 and all other registers read 0.
